// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter/sequencer for the shared external memory port
//
// Purpose: shares one valid/ready memory bus between instruction fetch (imem)
// and load/store (dmem). One transaction at a time, bus signals driven from
// copies latched at grant, dmem has priority, fetch is protected from
// starvation, and a stalled bus transaction is aborted after a timeout.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   imem_req_i, imem_addr_i         fetch request (held until imem_ready_o)
//   imem_rdata_o, imem_ready_o,
//   imem_err_o                      fetch data, completion pulse, abort pulse
//   dmem_req_i, dmem_we_i,
//   dmem_addr_i, dmem_wdata_i,
//   dmem_wstrb_i                    load/store request (held until dmem_ready_o)
//   dmem_rdata_o, dmem_ready_o,
//   dmem_err_o                      load data, completion pulse, abort pulse
//   mem_valid_o, mem_write_o,
//   mem_addr_o, mem_wdata_o,
//   mem_wstrb_o                     external request, from latched copies
//   mem_rdata_i, mem_ready_i        external response
//   grant_o                         owner: 00 none, 01 imem, 10 dmem
module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_ready_o,
  output logic        imem_err_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o,
  output logic        mem_valid_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [1:0]  grant_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // State encoding doubles as the grant_o value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS_I = 2'b01,
    BUS_D = 2'b10
  } state_t;

  state_t        state;
  logic [3:0]    starve_cnt;
  logic [TW-1:0] to_cnt;
  logic [31:0]   lat_addr;
  logic          lat_we;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wstrb;

  logic in_bus;
  logic to_hit;
  logic done;
  logic pick_i;

  assign in_bus = (state != IDLE);
  // A real response in the last allowed cycle wins over the abort.
  assign to_hit = (TIMEOUT_CYCLES != 0) && in_bus && !mem_ready_i && (to_cnt == TO_LAST);
  assign done   = in_bus && (mem_ready_i || to_hit);
  // Fetch wins when it is alone or has waited out STARVE_LIMIT dmem grants.
  assign pick_i = imem_req_i && (!dmem_req_i || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_i) begin
            state      <= BUS_I;
            lat_addr   <= imem_addr_i;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            starve_cnt <= '0;
          end else if (dmem_req_i) begin
            state     <= BUS_D;
            lat_addr  <= dmem_addr_i;
            lat_we    <= dmem_we_i;
            lat_wdata <= dmem_wdata_i;
            lat_wstrb <= dmem_we_i ? dmem_wstrb_i : 4'b0000;
            if (!imem_req_i)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        default: begin
          if (done)
            state <= IDLE;
          else
            to_cnt <= to_cnt + 1'b1;
        end
      endcase
    end
  end

  assign grant_o     = state;
  assign mem_valid_o = in_bus;
  assign mem_write_o = in_bus && lat_we;
  assign mem_addr_o  = in_bus ? lat_addr  : 32'h0;
  assign mem_wdata_o = in_bus ? lat_wdata : 32'h0;
  assign mem_wstrb_o = in_bus ? lat_wstrb : 4'b0000;

  assign imem_ready_o = (state == BUS_I) && done;
  assign imem_err_o   = (state == BUS_I) && to_hit;
  assign imem_rdata_o = ((state == BUS_I) && mem_ready_i) ? mem_rdata_i : 32'h0;

  assign dmem_ready_o = (state == BUS_D) && done;
  assign dmem_err_o   = (state == BUS_D) && to_hit;
  assign dmem_rdata_o = ((state == BUS_D) && mem_ready_i) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr),
    .imem_rdata_o(imem_rdata), .imem_ready_o(imem_ready), .imem_err_o(imem_err),
    .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr),
    .dmem_wdata_i(dmem_wdata), .dmem_wstrb_i(dmem_wstrb),
    .dmem_rdata_o(dmem_rdata), .dmem_ready_o(dmem_ready), .dmem_err_o(dmem_err),
    .mem_valid_o(mem_valid), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .grant_o(grant)
  );

  typedef struct {
    logic         ireq;
    logic [31:0]  iaddr;
    logic         dreq;
    logic         dwe;
    logic [31:0]  daddr;
    logic [31:0]  dwdata;
    logic [3:0]   dwstrb;
    logic         mready;
    logic [31:0]  mrdata;
    logic [139:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [139:0] mk_exp(input logic v, input logic w, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] s,
                                          input logic [1:0] g, input logic ir, input logic ie,
                                          input logic [31:0] ird, input logic dr, input logic de,
                                          input logic [31:0] drd);
    return {v, w, a, wd, s, g, ir, ie, ird, dr, de, drd};
  endfunction

  function automatic logic [139:0] outv();
    return {mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb, grant,
            imem_ready, imem_err, imem_rdata, dmem_ready, dmem_err, dmem_rdata};
  endfunction

  function automatic vec_t mkv(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic [3:0] dwstrb, input logic mready,
                               input logic [31:0] mrdata, input logic [139:0] exp);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
    v.dwdata = dwdata; v.dwstrb = dwstrb; v.mready = mready; v.mrdata = mrdata; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load with no response for 8 bus cycles; with answer=1 the memory responds in cycle 8.
  task automatic run_timeout(input bit answer);
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_0040;
    dmem_wdata = 32'h1111_1111; dmem_wstrb = 4'hF;
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    next_cycle();
    for (int b = 1; b <= 8; b++) begin
      if (answer && b == 8) begin
        mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
      end
      @(negedge clk);
      if (b < 8)
        chk($sformatf("to_wait%0d", b), {dmem_ready, dmem_err, mem_valid, mem_wstrb, grant},
            {1'b0, 1'b0, 1'b1, 4'b0000, 2'b10});
      else if (answer)
        chk("to_answered", {dmem_ready, dmem_err, dmem_rdata}, {1'b1, 1'b0, 32'h0000_0055});
      else
        chk("to_fire", {dmem_ready, dmem_err, dmem_rdata, imem_ready}, {1'b1, 1'b1, 32'h0, 1'b0});
      next_cycle();
    end
    dmem_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("to_after", {mem_valid, dmem_ready, grant}, '0);
    next_cycle();
  endtask

  logic [1:0] grants[$];
  logic [1:0] exp_grants[6];

  initial begin
    vecs[0]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[1]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                   mk_exp(1, 0, 32'h100, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    vecs[2]  = vecs[1];
    vecs[3]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h13,
                   mk_exp(1, 0, 32'h100, 0, 0, 2'b01, 1, 0, 32'h13, 0, 0, 0));
    vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[5]  = mkv(1, 32'h200, 1, 1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b1100, 0, 0, '0);
    vecs[6]  = mkv(1, 32'h200, 1, 1, 32'hFFFF_FFFC, 32'h0, 4'b0011, 0, 0,
                   mk_exp(1, 1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b1100, 2'b10, 0, 0, 0, 0, 0, 0));
    vecs[7]  = mkv(1, 32'h200, 1, 1, 32'hFFFF_FFFC, 32'h0, 4'b0011, 1, 32'h1234_5678,
                   mk_exp(1, 1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b1100, 2'b10, 0, 0, 0, 1, 0, 32'h1234_5678));
    vecs[8]  = mkv(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[9]  = mkv(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555,
                   mk_exp(1, 0, 32'h200, 0, 0, 2'b01, 1, 0, 32'hAAAA_5555, 0, 0, 0));
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, '0);
    vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    exp_grants[0] = 2'b10; exp_grants[1] = 2'b10; exp_grants[2] = 2'b10;
    exp_grants[3] = 2'b10; exp_grants[4] = 2'b01; exp_grants[5] = 2'b10;

    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", outv(), '0);
    next_cycle();
    rst = 1'b0;

    // Cycle-by-cycle vectors: single fetch, dmem-first arbitration, latched-input stability.
    for (int r = 0; r < 12; r++) begin
      imem_req = vecs[r].ireq; imem_addr = vecs[r].iaddr;
      dmem_req = vecs[r].dreq; dmem_we = vecs[r].dwe; dmem_addr = vecs[r].daddr;
      dmem_wdata = vecs[r].dwdata; dmem_wstrb = vecs[r].dwstrb;
      mem_ready = vecs[r].mready; mem_rdata = vecs[r].mrdata;
      @(negedge clk);
      chk($sformatf("row%0d", r), outv(), vecs[r].exp);
      next_cycle();
    end
    clear_inputs();

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Both requesters held continuously: four dmem grants, then imem, then dmem again.
    imem_req = 1'b1; imem_addr = 32'h400;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h80;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("one_ready%0d", c), {imem_ready & dmem_ready}, '0);
      if (mem_valid) grants.push_back(grant);
      next_cycle();
    end
    clear_inputs();
    chk("starve_count", grants.size(), 6);
    for (int g = 0; g < 6 && g < grants.size(); g++)
      chk($sformatf("starve_g%0d", g), grants[g], exp_grants[g]);
    @(negedge clk);
    next_cycle();

    // Reset asserted during BUS_I kills the transaction immediately.
    imem_req = 1'b1; imem_addr = 32'h300;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("rst_pre", {mem_valid, grant, mem_addr}, {1'b1, 2'b01, 32'h300});
    #2;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    rst = 1'b1;
    #1;
    chk("rst_mid", {mem_valid, grant, imem_ready, imem_rdata, mem_addr}, '0);
    next_cycle();
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_idle", {mem_valid, grant, imem_ready}, '0);
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("rst_regrant", {mem_valid, grant, mem_addr, imem_ready, imem_rdata},
        {1'b1, 2'b01, 32'h300, 1'b1, 32'h99});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("final_idle", outv(), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer sharing the single external memory port between instruction fetch (imem) and load/store (dmem).
- Sits between the fetch stage / load-store interface and the external valid/ready memory bus.
- Grants one transaction at a time. Holds bus signals stable from registered copies. Data side has priority, with starvation protection for fetch and a per-transaction timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive dmem grants issued while imem waits before imem is forced next; range 1..15.
- TIMEOUT_CYCLES, 256: bus cycles without mem_ready_i before the transaction is aborted; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- imem_req_i  input  1  fetch request; held until imem_ready_o
- imem_addr_i  input  32  fetch address
- imem_rdata_o  output  32  fetch read data; valid while imem_ready_o
- imem_ready_o  output  1  fetch completion pulse
- imem_err_o  output  1  fetch timeout-abort pulse, coincident with imem_ready_o
- dmem_req_i  input  1  load/store request; held until dmem_ready_o
- dmem_we_i  input  1  1 = store
- dmem_addr_i  input  32  load/store address
- dmem_wdata_i  input  32  store data, already lane-aligned
- dmem_wstrb_i  input  4  store byte strobes
- dmem_rdata_o  output  32  load read data, raw word
- dmem_ready_o  output  1  load/store completion pulse
- dmem_err_o  output  1  load/store timeout-abort pulse
- mem_valid_o  output  1  external request valid
- mem_write_o  output  1  external write enable
- mem_addr_o  output  32  external address
- mem_wdata_o  output  32  external write data
- mem_wstrb_o  output  4  external strobes; 0000 on reads
- mem_rdata_i  input  32  external read data
- mem_ready_i  input  1  external completion
- grant_o  output  2  current owner: 00 none, 01 imem, 10 dmem

Behaviour:
- FSM states:
  - IDLE: arbitration.
  - BUS_I: imem owns the bus.
  - BUS_D: dmem owns the bus.
- Reset:
  - State goes to IDLE. Starvation and timeout counters clear. Latched request registers clear.
  - All outputs are 0, including mem_valid_o, both ready/err outputs, both rdata outputs, and grant_o.
  - Reset asserted mid-transaction drops mem_valid_o immediately (asynchronous), with no completion pulse.
- Arbitration (IDLE, cycle N):
  - Only dmem requesting: latch dmem request and go to BUS_D.
  - Only imem requesting: latch imem request and go to BUS_I.
  - Both requesting: dmem wins, unless starve_cnt == STARVE_LIMIT, in which case imem wins.
  - In BUS_x from cycle N+1: mem_valid_o=1; mem_* driven from latched copies; grant_o reflects owner.
- Latched copies:
  - Address, write enable, write data and strobes are captured at grant.
  - Changes on requester inputs during BUS_x are ignored.
  - The imem path always drives mem_write_o=0 and mem_wstrb_o=0000.
  - For dmem, mem_wstrb_o is forced to 0000 when dmem_we_i was 0.
- Completion:
  - In BUS_x, mem_ready_i=1 gives a combinational same-cycle owner ready pulse (1 cycle).
  - Owner rdata is driven from mem_rdata_i in that cycle and is 0 otherwise; the non-owner sees 0.
  - Next state is IDLE.
  - Minimum transaction occupancy is 2 cycles (arbitration + 1 bus cycle); back-to-back grants are therefore separated by one IDLE cycle.
- mem_ready_i while in IDLE is ignored.
- Starvation counter (4 bits):
  - Increments on each dmem grant made while imem_req_i=1.
  - Clears on any imem grant.
  - Clears in IDLE when imem_req_i=0.
  - Saturates at STARVE_LIMIT.
- Timeout counter:
  - Clears on entering BUS_x and increments each BUS_x cycle without mem_ready_i.
  - When it reaches TIMEOUT_CYCLES-1 with mem_ready_i=0: owner ready and err pulse together, rdata=0, mem_valid_o drops, next state IDLE.
  - If mem_ready_i and timeout occur in the same cycle: normal completion, no err.
  - TIMEOUT_CYCLES=0: the counter never fires.
- If a requester drops its request during BUS_x, the transaction still completes on the bus. The ready pulse is still generated, and requesters must ignore unrequested pulses.
- At most one of imem_ready_o / dmem_ready_o is high in any cycle.

Test Plan:
- Single fetch: imem_req_i=1, addr 0x0000_0100, memory ready after 3 cycles with 0x0000_0013 → mem_valid_o from cycle 1, mem_write_o=0, imem_ready_o one pulse with imem_rdata_o=0x0000_0013, grant_o 01→00.
- Simultaneous: both requests, dmem store addr 0x2000_0004, wdata 0xDEADBEEF, wstrb 1100 → dmem granted first (grant_o=10, mem_wstrb_o=1100), then imem in next arbitration.
- Starvation with STARVE_LIMIT=4: dmem and imem both held continuously → exactly 4 dmem transactions, then 1 imem, then the counter clears and dmem resumes.
- Timeout with TIMEOUT_CYCLES=8: dmem load, mem_ready_i never asserted → dmem_ready_o and dmem_err_o high on bus cycle 8, dmem_rdata_o=0, mem_valid_o=0 next cycle. Repeat with mem_ready_i on cycle 8 → no err.
- Input stability: change dmem_addr_i to 0xFFFF_FFFC during BUS_D → mem_addr_o keeps the latched 0x2000_0004.
- Reset mid-transaction: assert rst_i during BUS_I → mem_valid_o, grant_o and ready outputs 0 immediately; after release, a new request arbitrates normally.
